hyperbus_trx_arbiter: RTL and testbench

Sequences the hyperbus PHY transaction interface and shares it between two requesters: the AXI read path and the AXI write path. It grants round-robin and decodes the chip select from the address. It splits long bursts into PHY chunks of at most MaxBurst words and enforces the configurable CS-high idle time (tCSHI) between chunks. It sits between the AXI front-end and the PHY, and allows only one PHY transaction outstanding at a time.

---
 rtl/hyperbus_trx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_hyperbus_trx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_trx_arbiter.sv
// Round-robin arbiter between AXI read/write paths onto the single-outstanding
// hyperbus PHY transaction port; splits bursts into MaxBurst chunks with tCSHI gaps.
module hyperbus_trx_arbiter #(
    parameter int unsigned NumChips     = 2,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned LenWidth     = 16,
    parameter int unsigned MaxBurst     = 256,
    parameter int unsigned ChipSizeLog2 = 22,
    parameter int unsigned TcshiWidth   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rd_valid_i,
    output logic                        rd_ready_o,
    input  logic [AddrWidth-1:0]        rd_addr_i,
    input  logic [LenWidth-1:0]         rd_len_i,
    output logic                        rd_done_o,
    output logic                        rd_err_o,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [AddrWidth-1:0]        wr_addr_i,
    input  logic [LenWidth-1:0]         wr_len_i,
    output logic                        wr_done_o,
    output logic                        wr_err_o,
    input  logic [TcshiWidth-1:0]       cfg_t_cshi_i,
    output logic                        phy_valid_o,
    input  logic                        phy_ready_i,
    output logic                        phy_write_o,
    output logic [NumChips-1:0]         phy_cs_o,
    output logic [AddrWidth-1:0]        phy_addr_o,
    output logic [$clog2(MaxBurst):0]   phy_len_o,
    input  logic                        phy_done_i,
    output logic                        busy_o
);

    localparam int unsigned PhyLenW = $clog2(MaxBurst) + 1;
    localparam int unsigned CmpW    = (LenWidth > PhyLenW) ? LenWidth : PhyLenW;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CS_IDLE   = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    logic [2:0]             state_q;
    logic                   last_wr_q;
    logic                   dir_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [LenWidth-1:0]    rem_q;
    logic [LenWidth-1:0]    chunk_q;
    logic [TcshiWidth-1:0]  cshi_q;
    logic                   done_q;
    logic                   err_q;
    logic                   phy_write_q;
    logic [NumChips-1:0]    phy_cs_q;
    logic [AddrWidth-1:0]   phy_addr_q;
    logic [PhyLenW-1:0]     phy_len_q;

    logic                   rd_grant;
    logic                   wr_grant;
    logic                   accept_ok;
    logic [AddrWidth-1:0]   chip_idx;
    logic [NumChips-1:0]    cs_dec;
    logic                   chip_ok;
    logic [CmpW-1:0]        rem_ext;
    logic [CmpW-1:0]        chunk_ext;

    // A tie goes to whichever requester was not served last.
    assign rd_grant  = rd_valid_i && (!wr_valid_i || last_wr_q);
    assign wr_grant  = wr_valid_i && (!rd_valid_i || !last_wr_q);
    assign accept_ok = (state_q == S_IDLE) && !rst_i;
    assign rd_ready_o = accept_ok && rd_grant;
    assign wr_ready_o = accept_ok && wr_grant;

    assign chip_idx  = addr_q >> ChipSizeLog2;
    assign rem_ext   = CmpW'(rem_q);
    assign chunk_ext = (rem_ext > CmpW'(MaxBurst)) ? CmpW'(MaxBurst) : rem_ext;

    always_comb begin
        cs_dec  = '0;
        chip_ok = 1'b0;
        for (int unsigned i = 0; i < NumChips; i++) begin
            if (chip_idx == AddrWidth'(i)) begin
                cs_dec[i] = 1'b1;
                chip_ok   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            last_wr_q   <= 1'b1;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            cshi_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            phy_write_q <= 1'b0;
            phy_cs_q    <= '0;
            phy_addr_q  <= '0;
            phy_len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_ready_o) begin
                        addr_q    <= rd_addr_i;
                        rem_q     <= rd_len_i;
                        dir_q     <= 1'b0;
                        last_wr_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end else if (wr_ready_o) begin
                        addr_q    <= wr_addr_i;
                        rem_q     <= wr_len_i;
                        dir_q     <= 1'b1;
                        last_wr_q <= 1'b1;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // remaining is only zero here on the first chunk of a len==0 request
                    if (rem_q == '0 || !chip_ok) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        phy_write_q <= dir_q;
                        phy_cs_q    <= cs_dec;
                        phy_addr_q  <= addr_q;
                        phy_len_q   <= PhyLenW'(chunk_ext);
                        chunk_q     <= LenWidth'(chunk_ext);
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (phy_ready_i) begin
                        addr_q  <= addr_q + AddrWidth'(chunk_q);
                        rem_q   <= rem_q - chunk_q;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (phy_done_i) begin
                        cshi_q  <= cfg_t_cshi_i;
                        state_q <= (cfg_t_cshi_i != '0) ? S_CS_IDLE : S_NEXT;
                    end
                end
                S_CS_IDLE: begin
                    cshi_q <= cshi_q - 1'b1;
                    if (cshi_q == TcshiWidth'(1)) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (rem_q != '0) begin
                        state_q <= S_DECODE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_done_o   = done_q && !dir_q;
    assign rd_err_o    = err_q && !dir_q;
    assign wr_done_o   = done_q && dir_q;
    assign wr_err_o    = err_q && dir_q;
    assign phy_valid_o = (state_q == S_ISSUE);
    assign phy_write_o = phy_write_q;
    assign phy_cs_o    = phy_cs_q;
    assign phy_addr_o  = phy_addr_q;
    assign phy_len_o   = phy_len_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hyperbus_trx_arbiter.sv
// Bench for hyperbus_trx_arbiter: vector table of requests, PHY responder model,
// and queue scoreboard of expected PHY chunks and done pulses.
module tb_hyperbus_trx_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rd_valid_i, rd_ready_o, rd_done_o, rd_err_o;
    logic [31:0] rd_addr_i;
    logic [15:0] rd_len_i;
    logic        wr_valid_i, wr_ready_o, wr_done_o, wr_err_o;
    logic [31:0] wr_addr_i;
    logic [15:0] wr_len_i;
    logic [3:0]  cfg_t_cshi_i;
    logic        phy_valid_o, phy_ready_i, phy_write_o, phy_done_i, busy_o;
    logic [1:0]  phy_cs_o;
    logic [31:0] phy_addr_o;
    logic [8:0]  phy_len_o;

    hyperbus_trx_arbiter #(
        .NumChips(2), .AddrWidth(32), .LenWidth(16),
        .MaxBurst(256), .ChipSizeLog2(22), .TcshiWidth(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
        .rd_len_i(rd_len_i), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
        .wr_len_i(wr_len_i), .wr_done_o(wr_done_o), .wr_err_o(wr_err_o),
        .cfg_t_cshi_i(cfg_t_cshi_i),
        .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i), .phy_write_o(phy_write_o),
        .phy_cs_o(phy_cs_o), .phy_addr_o(phy_addr_o), .phy_len_o(phy_len_o),
        .phy_done_i(phy_done_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          w;
        logic [1:0]  cs;
        logic [31:0] addr;
        logic [8:0]  len;
    } phy_t;

    typedef struct {
        bit w;
        bit err;
    } done_t;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [15:0] len;
        logic [3:0]  tcshi;
        int          rdy_dly;
        int          done_dly;
        int          exp_chunks;
        bit          exp_err;
    } vec_t;

    phy_t  exp_phy[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_hs = 0;
    int ready_delay = 0;
    int done_delay = 1;
    int last_gap = -1;
    bit last_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference model: expected chunks and done for one accepted request.
    function automatic void model_req(input bit w, input logic [31:0] a, input logic [15:0] l);
        logic [31:0] ad = a;
        int unsigned rem = l;
        int unsigned ch;
        phy_t p;
        if (rem == 0) begin
            exp_done.push_back('{w, 1'b1});
            return;
        end
        while (rem > 0) begin
            if ((ad >> 22) >= 2) begin
                exp_done.push_back('{w, 1'b1});
                return;
            end
            ch = (rem > 256) ? 256 : rem;
            p.w = w;
            p.cs = ((ad >> 22) == 0) ? 2'b01 : 2'b10;
            p.addr = ad;
            p.len = 9'(ch);
            exp_phy.push_back(p);
            ad = ad + 32'(ch);
            rem = rem - ch;
        end
        exp_done.push_back('{w, 1'b0});
    endfunction

    // PHY responder: checks presented chunks while stalled and on acceptance.
    initial begin : phy_model
        int wait_cnt = 0;
        int pend = 0;
        int gap = 0;
        bit gap_on = 0;
        phy_t e;
        phy_ready_i = 1'b0;
        phy_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            phy_ready_i = 1'b0;
            phy_done_i = 1'b0;
            if (rst_i) begin
                wait_cnt = 0;
                pend = 0;
                gap_on = 0;
            end else begin
                if (gap_on) begin
                    if (phy_valid_o) begin
                        last_gap = gap;
                        gap_on = 0;
                    end else begin
                        gap++;
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        phy_done_i = 1'b1;
                        gap_on = 1;
                        gap = 0;
                    end
                end
                if (phy_valid_o) begin
                    check("phy_txn_expected", 64'(exp_phy.size() != 0), 1);
                    if (exp_phy.size() != 0) begin
                        e = exp_phy[0];
                        check("phy_write", phy_write_o, e.w);
                        check("phy_cs", phy_cs_o, e.cs);
                        check("phy_addr", phy_addr_o, e.addr);
                        check("phy_len", phy_len_o, e.len);
                        if (wait_cnt >= ready_delay) begin
                            phy_ready_i = 1'b1;
                            void'(exp_phy.pop_front());
                            n_hs++;
                            pend = done_delay;
                            wait_cnt = 0;
                        end else begin
                            wait_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin : done_mon
        done_t d;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                check("both_ready", rd_ready_o & wr_ready_o, 0);
                check("rd_err_without_done", rd_err_o & ~rd_done_o, 0);
                check("wr_err_without_done", wr_err_o & ~wr_done_o, 0);
                if (rd_done_o || wr_done_o) begin
                    check("done_expected", 64'(exp_done.size() != 0), 1);
                    check("done_single", rd_done_o & wr_done_o, 0);
                    if (exp_done.size() != 0) begin
                        d = exp_done.pop_front();
                        check("done_dir", wr_done_o, d.w);
                        check("done_err", rd_err_o | wr_err_o, d.err);
                    end
                    last_err = rd_err_o | wr_err_o;
                end
            end
        end
    end

    task automatic do_req(input bit w, input logic [31:0] a, input logic [15:0] l);
        bit got = 0;
        @(negedge clk_i);
        if (w) begin
            wr_valid_i = 1'b1; wr_addr_i = a; wr_len_i = l;
        end else begin
            rd_valid_i = 1'b1; rd_addr_i = a; rd_len_i = l;
        end
        for (int c = 0; c < 500; c++) begin
            #1;
            if (w ? wr_ready_o : rd_ready_o) begin
                model_req(w, a, l);
                got = 1;
                @(posedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        if (!got) timeout_fail("req_accept");
        @(negedge clk_i);
        rd_valid_i = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (exp_done.size() == 0 && exp_phy.size() == 0 && !busy_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("req_complete");
    endtask

    // Both requesters held valid; grants must alternate starting with exp_first.
    task automatic tie_run(input int n, input bit exp_first);
        bit exp_w = exp_first;
        bit got;
        @(negedge clk_i);
        rd_valid_i = 1'b1; rd_addr_i = 32'h40; rd_len_i = 16'd4;
        wr_valid_i = 1'b1; wr_addr_i = 32'h80; wr_len_i = 16'd4;
        for (int g = 0; g < n; g++) begin
            got = 0;
            for (int c = 0; c < 500; c++) begin
                #1;
                if (rd_ready_o || wr_ready_o) begin
                    got = 1;
                    break;
                end
                @(negedge clk_i);
            end
            if (!got) begin
                timeout_fail("tie_grant");
                break;
            end
            check("tie_rd_ready", rd_ready_o, !exp_w);
            check("tie_wr_ready", wr_ready_o, exp_w);
            model_req(exp_w, exp_w ? 32'h80 : 32'h40, 16'd4);
            exp_w = !exp_w;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rd_valid_i = 1'b0;
        wr_valid_i = 1'b0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_phy_valid"}, phy_valid_o, 0);
        check({tag, "_phy_write"}, phy_write_o, 0);
        check({tag, "_phy_cs"}, phy_cs_o, 0);
        check({tag, "_phy_addr"}, phy_addr_o, 0);
        check({tag, "_phy_len"}, phy_len_o, 0);
        check({tag, "_dones"}, {rd_done_o, rd_err_o, wr_done_o, wr_err_o}, 0);
        check({tag, "_readys"}, {rd_ready_o, wr_ready_o}, 0);
    endtask

    vec_t vecs[8];

    initial begin : main
        int hs0;
        bit got;
        vecs[0] = '{0, 32'h0000_0100, 16'd4,   4'd0, 1,  1, 1, 0};
        vecs[1] = '{1, 32'h003F_FF00, 16'd600, 4'd0, 10, 2, 3, 0};
        vecs[2] = '{0, 32'h0080_0000, 16'd4,   4'd0, 0,  1, 0, 1};
        vecs[3] = '{0, 32'h0000_0200, 16'd0,   4'd1, 0,  1, 0, 1};
        vecs[4] = '{1, 32'h003F_FFF0, 16'd32,  4'd2, 3,  4, 1, 0};
        vecs[5] = '{0, 32'h007F_FF80, 16'd384, 4'd1, 0,  1, 1, 1};
        vecs[6] = '{1, 32'h0000_0010, 16'd256, 4'd5, 2,  1, 1, 0};
        vecs[7] = '{0, 32'h0000_0020, 16'd257, 4'd0, 0,  3, 2, 0};

        rst_i = 1'b1;
        rd_valid_i = 1'b0; rd_addr_i = '0; rd_len_i = '0;
        wr_valid_i = 1'b0; wr_addr_i = '0; wr_len_i = '0;
        cfg_t_cshi_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        // First tie after reset goes to read, then alternates.
        tie_run(4, 1'b0);

        foreach (vecs[i]) begin
            cfg_t_cshi_i = vecs[i].tcshi;
            ready_delay = vecs[i].rdy_dly;
            done_delay = vecs[i].done_dly;
            hs0 = n_hs;
            last_err = 1'bx;
            do_req(vecs[i].w, vecs[i].addr, vecs[i].len);
            wait_idle();
            check($sformatf("vec%0d_chunks", i), n_hs - hs0, vecs[i].exp_chunks);
            check($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
        end

        // CS-high gap between chunks of one burst.
        ready_delay = 0;
        done_delay = 2;
        cfg_t_cshi_i = 4'd3;
        last_gap = -1;
        do_req(0, 32'h1000, 16'd300);
        wait_idle();
        check("tcshi3_gap", last_gap, 5);
        cfg_t_cshi_i = 4'd0;
        last_gap = -1;
        do_req(1, 32'h2000, 16'd300);
        wait_idle();
        check("tcshi0_gap", last_gap, 2);

        // Reset while waiting for phy_done_i: transaction dropped, no done.
        done_delay = 40;
        hs0 = n_hs;
        do_req(1, 32'h100, 16'd8);
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            if (n_hs != hs0) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail("rst_seq_handshake");
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        exp_phy.delete();
        exp_done.delete();
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        done_delay = 1;
        repeat (50) @(negedge clk_i);
        check("post_reset_idle", busy_o, 0);
        tie_run(2, 1'b0);

        repeat (5) @(negedge clk_i);
        check("final_phy_queue", exp_phy.size(), 0);
        check("final_done_queue", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
